mem_stall_ctrl: RTL
===================

# mem_stall_ctrl

Multi-cycle data-memory controller between the processor's memory stage and a banked main memory with fixed two-cycle read latency. Accepts one load or store at a time, holds the processor with `stall` until the access completes, and returns load data with a one-cycle `done` pulse. It replaces the single-cycle data memory path as the first step toward a stalling memory system.

## Interface
Parameters:
- `MEM_LAT`, 2: cycles from read issue (`mem_rd` accepted) to valid `mem_data_out`.
- `TIMEOUT`, 255: consecutive `mem_stall` cycles in REQ before an error abort.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr`  in  16  processor byte address.
- `data_in`  in  16  store data.
- `rd`  in  1  load request, level-sensitive, sampled in IDLE.
- `wr`  in  1  store request, level-sensitive, sampled in IDLE.
- `data_out`  out  16  registered load data, valid from the `done` cycle until the next accepted load.
- `stall`  out  1  processor must hold its state.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle error pulse.
- `mem_addr`  out  16  latched address to memory.
- `mem_data_in`  out  16  latched store data to memory.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `mem_data_out`  in  16  memory read data.
- `mem_stall`  in  1  bank busy; the strobe is not accepted this cycle.

## Operation
FSM states are IDLE, REQ, WAIT, DONE.

- IDLE:
  - With `rd` xor `wr`: latch `addr`, `data_in`, and the operation. Assert `stall` combinationally in the same cycle. Go to REQ.
  - With `rd` and `wr` both set: pulse `err`, accept nothing, keep `stall` = 0, stay in IDLE.
- REQ:
  - Drive `mem_rd` or `mem_wr` together with the latched `mem_addr` and `mem_data_in`.
  - If `mem_stall` = 1: stay in REQ and increment the timeout counter.
  - If `mem_stall` = 0: a write goes to DONE; a read clears the latency counter and goes to WAIT.
  - If the timeout counter reaches `TIMEOUT`: pulse `err`, go to IDLE, leave `data_out` unchanged.
- WAIT:
  - The latency counter counts up to `MEM_LAT`-1.
  - In the final WAIT cycle, capture `mem_data_out` into `data_out` and go to DONE.
- DONE: `done` = 1, `stall` = 0, `rd` and `wr` are ignored; go to IDLE. The processor advances on this edge.
- `stall` = (IDLE & valid request) | REQ | WAIT.
- `mem_rd` and `mem_wr` are asserted only in REQ, decoded from state and never registered separately.
- Both counters are 8-bit, saturating, and cleared on entry to REQ.

## Timing
- Reset values: state IDLE, `data_out` = 0, `stall` = 0, `done` = 0, `err` = 0, `mem_rd` = 0, `mem_wr` = 0, `mem_addr` = 0, `mem_data_in` = 0.
- Read accepted in cycle T with no bank stall:
  - REQ at T+1, WAIT at T+2..T+1+`MEM_LAT`.
  - `done` and valid `data_out` at T+2+`MEM_LAT`, i.e. T+4 by default.
- Write accepted in cycle T with no bank stall: REQ at T+1, `done` at T+2.
- Each `mem_stall` cycle in REQ adds exactly one cycle of latency.
- Back-to-back requests: the earliest next acceptance is the cycle after DONE. Minimum spacing is 5 cycles for reads and 3 cycles for writes.
- Asynchronous reset mid-access: all outputs drop immediately to their reset values and the in-flight access is abandoned. The memory may still complete a read; the controller ignores it.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - In IDLE, a request with `addr[0]` = 1 pulses `err` and issues no memory strobe.
  - `stall` stays 0 and the state stays IDLE.
- `MEM_ALIGN_CHECK_EN` undefined: the address is passed through unchanged and unaligned accesses proceed normally.

## Structure
- Shared package `mem_ctrl_pkg` holds:
  - the state encoding (2-bit: IDLE=0, REQ=1, WAIT=2, DONE=3);
  - the operation encoding;
  - the defaults for `MEM_LAT` and `TIMEOUT`.
- Sub-module `mem_sat_counter`: 8-bit saturating counter with clear and enable. It is instantiated twice, once for latency and once for timeout.

## Test plan
- Load from `addr` = 0x0010 with memory returning 0xBEEF and no `mem_stall` → `stall` high for cycles T..T+3, `done` and `data_out` = 0xBEEF at T+4, `mem_rd` high only at T+1.
- Store 0x1234 to 0x0020 → `mem_wr` = 1 with `mem_addr` = 0x0020 and `mem_data_in` = 0x1234 at T+1, `done` at T+2.
- Load with `mem_stall` held for 3 cycles in REQ → `done` at T+7; `data_out` is correct.
- `rd` = `wr` = 1 → one-cycle `err`, no `stall`, no strobe. With `MEM_ALIGN_CHECK_EN` defined, a load at 0x0011 → `err`, no strobe.
- `mem_stall` stuck at 1 with `TIMEOUT` = 4 → `err` pulse after the 4th REQ stall cycle, return to IDLE. Separately, `rst` asserted during WAIT → `stall` and `mem_rd` = 0 immediately and `data_out` = 0.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the stalling data-memory controller:
//   - state_e : 2-bit controller state encoding (IDLE=0, REQ=1, WAIT=2, DONE=3)
//   - op_e    : latched operation kind (read / write)
//   - MEM_LAT_DEFAULT / TIMEOUT_DEFAULT : parameter defaults for mem_stall_ctrl
//   - CNT_W   : width of the latency and timeout counters
// -----------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int MEM_LAT_DEFAULT = 2;
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Counter value seen in the last cycle of an n-cycle interval that starts at 0.
  function automatic logic [CNT_W-1:0] cnt_last(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage : mem_ctrl_pkg

// File: rtl/mem_sat_counter.sv
// -----------------------------------------------------------------------------
// mem_sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
// Clear has priority over enable.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (counter -> 0)
//   clr_i  in   synchronous clear
//   en_i   in   count enable
//   cnt_o  out  current count (CNT_W bits)
// -----------------------------------------------------------------------------
module mem_sat_counter
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is only ever written with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule : mem_sat_counter

// File: rtl/mem_stall_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stall_ctrl
// Multi-cycle data-memory controller between the processor memory stage and a
// banked main memory with a fixed read latency. One access is in flight at a
// time; the processor is held with `stall` until the access completes, and
// completion is signalled with a one-cycle `done` pulse.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : a request with addr[0]=1 in IDLE is rejected with `err`
//   undefined : addresses pass through unchanged, odd addresses are accepted
//
// Parameters:
//   MEM_LAT  cycles from read issue to valid mem_data_out (1..256)
//   TIMEOUT  consecutive mem_stall cycles in REQ before abort (1..256)
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   addr, data_in    processor byte address / store data
//   rd, wr           load / store request (level, sampled in IDLE)
//   data_out         registered load data, valid from `done` on
//   stall            processor hold (combinational in the accepting cycle)
//   done, err        registered one-cycle completion / error pulses
//   mem_addr         latched address to memory
//   mem_data_in      latched store data to memory
//   mem_rd, mem_wr   memory strobes, asserted only in REQ
//   mem_data_out     memory read data
//   mem_stall        bank busy: the strobe is not taken this cycle
//
// `err` is registered: it is high in the cycle after the rejected request or
// after the REQ cycle whose stall brought the timeout counter to TIMEOUT.
// -----------------------------------------------------------------------------
module mem_stall_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_stall
);

  localparam logic [CNT_W-1:0] LAT_LAST = cnt_last(MEM_LAT);
  localparam logic [CNT_W-1:0] TMO_LAST = cnt_last(TIMEOUT);

  state_e      state_q;
  op_e         op_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        done_q;
  logic        err_q;

  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] tmo_cnt;

  logic req_misalign;
  logic in_idle;
  logic accept;
  logic idle_err;
  logic in_req;
  logic in_wait;
  logic granted;
  logic timeout_hit;
  logic wait_last;

`ifdef MEM_ALIGN_CHECK_EN
  assign req_misalign = (rd | wr) & addr[0];
`else
  assign req_misalign = 1'b0;
`endif

  assign in_idle  = (state_q == ST_IDLE);
  assign in_req   = (state_q == ST_REQ);
  assign in_wait  = (state_q == ST_WAIT);

  // rst gates acceptance so `stall` drops the moment reset is asserted, even
  // while a request is still being presented.
  assign accept   = ~rst & in_idle & (rd ^ wr) & ~req_misalign;
  assign idle_err = in_idle & ((rd & wr) | req_misalign);

  assign granted     = in_req & ~mem_stall;
  // The abort fires on the stall cycle that would bring the count to TIMEOUT.
  assign timeout_hit = in_req & mem_stall & (tmo_cnt == TMO_LAST);
  assign wait_last   = in_wait & (lat_cnt == LAT_LAST);

  // Latency counter restarts when the read strobe is taken, so WAIT always
  // begins at 0; timeout counter restarts on every accepted request.
  mem_sat_counter u_lat_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept | granted),
    .en_i  (in_wait),
    .cnt_o (lat_cnt)
  );

  mem_sat_counter u_tmo_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (in_req & mem_stall),
    .cnt_o (tmo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q    <= wr ? OP_WRITE : OP_READ;
            addr_q  <= addr;
            wdata_q <= data_in;
            state_q <= ST_REQ;
          end
          if (idle_err) begin
            err_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (granted) begin
            if (op_q == OP_WRITE) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (wait_last) begin
            rdata_q <= mem_data_out;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall       = accept | in_req | in_wait;
  assign mem_rd      = in_req & (op_q == OP_READ);
  assign mem_wr      = in_req & (op_q == OP_WRITE);
  assign mem_addr    = addr_q;
  assign mem_data_in = wdata_q;
  assign data_out    = rdata_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule : mem_stall_ctrl
